decoder_nto2n_seq: RTL and testbench

- Parametrised, registered N-to-2^N binary-to-one-hot decoder.
- Adds a valid/ready input handshake, an enable, and a self-running scan mode that walks the one-hot output through all indices.
- Used for digit/row strobing and address select in display and memory-select datapaths.
- The output is registered so that downstream select lines are glitch-free.

---
 rtl/decoder_nto2n_seq.sv | 139 +++++++++++++
 tb/tb_decoder_nto2n_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with a valid/ready input, an enable,
// and a self-running scan mode that walks the one-hot output over all indices.
// Optional build macro: DECODER_SKIP_MASK_EN adds skip_mask; scan skips masked
// indices and masked direct selects produce an all-zero output.
module decoder_nto2n_seq #(
    parameter int unsigned N        = 4,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          i,
`ifdef DECODER_SKIP_MASK_EN
    input  logic [(2**N)-1:0]     skip_mask,
`endif
    output logic [(2**N)-1:0]     d,
    output logic                  d_valid,
    output logic [N-1:0]          cur_idx
);

    localparam int unsigned OUT_W = 2**N;
    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_n;
    logic [PRE_W-1:0] pre_eff;
    logic [OUT_W-1:0] d_n;
    logic             d_valid_n;
    logic [N-1:0]     idx_n;
    logic             blanked;
    logic             blanked_n;
    logic             mode_q;
    logic             mode_q_n;
    logic [OUT_W-1:0] mask_v;
    logic [N-1:0]     scan_nxt;
    logic             scan_found;
    logic [N-1:0]     cand;

    function automatic logic [OUT_W-1:0] onehot(input logic [N-1:0] x);
        logic [OUT_W-1:0] v;
        v    = '0;
        v[x] = 1'b1;
        return v;
    endfunction

    // Indices excluded from selection (none unless the skip feature is built in)
`ifdef DECODER_SKIP_MASK_EN
    assign mask_v = skip_mask;
`else
    assign mask_v = '0;
`endif

    // Handshake is only offered in enabled direct mode and never during reset
    assign in_ready = en & ~mode & ~rst;

    // Next scan index: first unmasked position after cur_idx, with wrap
    always_comb begin
        scan_found = 1'b0;
        scan_nxt   = cur_idx;
        cand       = cur_idx;
        for (int unsigned k = 1; k <= OUT_W; k++) begin
            cand = N'(32'(cur_idx) + k);
            if (!scan_found && !mask_v[cand]) begin
                scan_found = 1'b1;
                scan_nxt   = cand;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        d_n       = d;
        d_valid_n = 1'b0;
        idx_n     = cur_idx;
        pre_n     = pre;
        blanked_n = blanked;
        mode_q_n  = mode_q;
        pre_eff   = mode_q ? pre : '0;
        if (!en) begin
            // Blank the output; index, prescaler and mode history freeze
            d_n       = '0;
            blanked_n = 1'b1;
        end else begin
            blanked_n = 1'b0;
            mode_q_n  = mode;
            if (!mode) begin
                pre_n = '0;
                if (in_valid) begin
                    idx_n     = i;
                    d_n       = onehot(i) & ~mask_v;
                    d_valid_n = 1'b1;
                end else if (blanked) begin
                    d_n       = onehot(cur_idx) & ~mask_v;
                    d_valid_n = 1'b1;
                end
            end else if (blanked) begin
                // Restore edge in scan mode: prescaler does not advance
                d_n       = onehot(cur_idx) & ~mask_v;
                d_valid_n = 1'b1;
                pre_n     = pre_eff;
            end else if (pre_eff == PRE_TERM) begin
                pre_n = '0;
                if (scan_found) begin
                    idx_n     = scan_nxt;
                    d_n       = onehot(scan_nxt);
                    d_valid_n = 1'b1;
                end else begin
                    d_n = '0;
                end
            end else begin
                pre_n = pre_eff + PRE_W'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d       <= '0;
            d_valid <= 1'b0;
            cur_idx <= '0;
            pre     <= '0;
            blanked <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            d       <= d_n;
            d_valid <= d_valid_n;
            cur_idx <= idx_n;
            pre     <= pre_n;
            blanked <= blanked_n;
            mode_q  <= mode_q_n;
        end
    end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed-vector bench for decoder_nto2n_seq (N=4, SCAN_DIV=4).
module tb_decoder_nto2n_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  i;
    logic [15:0] d;
    logic        d_valid;
    logic [3:0]  cur_idx;
`ifdef DECODER_SKIP_MASK_EN
    logic [15:0] skip_mask = '0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    decoder_nto2n_seq #(.N(4), .SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .i        (i),
`ifdef DECODER_SKIP_MASK_EN
        .skip_mask(skip_mask),
`endif
        .d        (d),
        .d_valid  (d_valid),
        .cur_idx  (cur_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_d;
        rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0; i = '0;
        #3;
        check("rst_d", 32'(d), 32'h0);
        check("rst_dv", 32'(d_valid), 32'h0);
        check("rst_idx", 32'(cur_idx), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("ready_direct", 32'(in_ready), 32'h1);

        // Single direct accept of index 9
        in_valid = 1'b1; i = 4'd9;
        tick();
        in_valid = 1'b0;
        check("dir9_d", 32'(d), 32'h0200);
        check("dir9_dv", 32'(d_valid), 32'h1);
        check("dir9_idx", 32'(cur_idx), 32'h9);
        tick();
        check("dir9_hold_d", 32'(d), 32'h0200);
        check("dir9_hold_dv", 32'(d_valid), 32'h0);

        // Back-to-back accepts 0, 15, 3
        in_valid = 1'b1; i = 4'd0;
        tick();
        check("b2b0_d", 32'(d), 32'h0001);
        check("b2b0_dv", 32'(d_valid), 32'h1);
        i = 4'd15;
        tick();
        check("b2b15_d", 32'(d), 32'h8000);
        check("b2b15_dv", 32'(d_valid), 32'h1);
        i = 4'd3;
        tick();
        check("b2b3_d", 32'(d), 32'h0008);
        check("b2b3_dv", 32'(d_valid), 32'h1);
        in_valid = 1'b0;
        tick();
        check("b2b_end_dv", 32'(d_valid), 32'h0);

        // Scan wrap from index 14
        in_valid = 1'b1; i = 4'd14;
        tick();
        in_valid = 1'b0;
        mode = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            exp_d = (t < 4) ? 16'h4000 : (t < 8) ? 16'h8000 : 16'h0001;
            check($sformatf("scan_d_t%0d", t), 32'(d), 32'(exp_d));
            check($sformatf("scan_dv_t%0d", t), 32'(d_valid), (t % 4 == 0) ? 32'h1 : 32'h0);
            check($sformatf("scan_ready_t%0d", t), 32'(in_ready), 32'h0);
        end
        check("scan_wrap_idx", 32'(cur_idx), 32'h0);

        // Run on to index 6 with prescaler at 2
        for (int t = 0; t < 26; t++) tick();
        check("pre_dis_idx", 32'(cur_idx), 32'h6);
        check("pre_dis_d", 32'(d), 32'h0040);

        // Disable for 5 cycles
        en = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            tick();
            check($sformatf("dis_d_t%0d", t), 32'(d), 32'h0);
            check($sformatf("dis_idx_t%0d", t), 32'(cur_idx), 32'h6);
            check($sformatf("dis_dv_t%0d", t), 32'(d_valid), 32'h0);
        end
        en = 1'b1;
        tick();
        check("reen_d", 32'(d), 32'h0040);
        check("reen_dv", 32'(d_valid), 32'h1);
        tick();
        check("reen_hold_d", 32'(d), 32'h0040);
        check("reen_hold_dv", 32'(d_valid), 32'h0);
        tick();
        check("reen_step_d", 32'(d), 32'h0080);
        check("reen_step_dv", 32'(d_valid), 32'h1);
        check("reen_step_idx", 32'(cur_idx), 32'h7);

        // Exit scan with prescaler mid-count, then re-enter
        tick();
        mode = 1'b0;
        #1;
        check("exit_ready", 32'(in_ready), 32'h1);
        tick();
        check("exit_d", 32'(d), 32'h0080);
        check("exit_dv", 32'(d_valid), 32'h0);
        check("exit_idx", 32'(cur_idx), 32'h7);
        mode = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            check($sformatf("entry_dv_t%0d", t), 32'(d_valid), (t == 4) ? 32'h1 : 32'h0);
        end
        check("entry_d", 32'(d), 32'h0100);
        check("entry_idx", 32'(cur_idx), 32'h8);

        // Disable and restore in direct mode
        mode = 1'b0; en = 1'b0;
        #1;
        check("dis_dir_ready", 32'(in_ready), 32'h0);
        tick();
        check("dis_dir_d", 32'(d), 32'h0);
        en = 1'b1;
        tick();
        check("restore_dir_d", 32'(d), 32'h0100);
        check("restore_dir_dv", 32'(d_valid), 32'h1);

`ifdef DECODER_SKIP_MASK_EN
        // Scan skipping masked indices 4..7, then fully masked hold
        in_valid = 1'b1; i = 4'd3;
        tick();
        in_valid = 1'b0;
        skip_mask = 16'h00F0;
        mode = 1'b1;
        for (int t = 0; t < 4; t++) tick();
        check("skip_d", 32'(d), 32'h0100);
        check("skip_idx", 32'(cur_idx), 32'h8);
        skip_mask = 16'hFFFF;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check($sformatf("allmask_dv_t%0d", t), 32'(d_valid), 32'h0);
        end
        check("allmask_d", 32'(d), 32'h0);
        check("allmask_idx", 32'(cur_idx), 32'h8);
        skip_mask = '0;
`endif

        // Asynchronous reset between edges during scan
        mode = 1'b1;
        for (int t = 0; t < 5; t++) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_d", 32'(d), 32'h0);
        check("arst_idx", 32'(cur_idx), 32'h0);
        check("arst_dv", 32'(d_valid), 32'h0);
        check("arst_ready", 32'(in_ready), 32'h0);
        tick();
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
